// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory line-port arbiter: FSM states, requester ids, line offset.
// Pure declarations, no logic.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic ID_IC = 1'b0;
    localparam logic ID_DC = 1'b1;

    localparam int LINE_OFFSET_BITS = 3;

endpackage

// File: rtl/mem_refill_arbiter_rr2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one not granted last.
// Purely combinational, zero latency; no backpressure of its own.
module arb_rr2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic vld,
    output logic id
);

    assign vld = req0 | req1;
    assign id  = (req0 & req1) ? ~last_grant : req1;

endmodule

// File: rtl/mem_refill_arbiter.sv
// Shares one main-memory line port between I-cache refills and D-cache line traffic.
// Latency: grant edge + MEM_LATENCY access cycles + one DONE cycle carrying the ack pulse.
// Backpressure: a requester holds req until its ack; the loser simply waits in IDLE.
module mem_refill_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int LINE_W      = 64,
    parameter int MEM_LATENCY = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_ack,
    output logic [LINE_W-1:0] ic_line,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [LINE_W-1:0] dc_wline,
    output logic              dc_ack,
    output logic [LINE_W-1:0] dc_line,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wline,
    input  logic [LINE_W-1:0] mem_rline,
    output logic              busy,
    output logic              grant_id
);

    localparam int CNT_W = $clog2(MEM_LATENCY + 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((1 << LINE_OFFSET_BITS) - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             last_grant;
    logic             pick_vld;
    logic             pick_id;
    logic             last_beat;
    logic [ADDR_W-1:0] pick_addr;

    arb_rr2 u_rr (
        .req0       (ic_req),
        .req1       (dc_req),
        .last_grant (last_grant),
        .vld        (pick_vld),
        .id         (pick_id)
    );

    assign last_beat = (cnt == CNT_W'(MEM_LATENCY - 1));
    assign pick_addr = ((pick_id == ID_DC) ? dc_addr : ic_addr) & ALIGN_MASK;

    // The mem_* registers double as the grant latches; they are zeroed outside ACCESS.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            last_grant <= ID_DC;
            ic_ack     <= 1'b0;
            dc_ack     <= 1'b0;
            ic_line    <= '0;
            dc_line    <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wline  <= '0;
            busy       <= 1'b0;
            grant_id   <= 1'b0;
        end else begin
            ic_ack <= 1'b0;
            dc_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        grant_id  <= pick_id;
                        busy      <= 1'b1;
                        mem_en    <= 1'b1;
                        mem_addr  <= pick_addr;
                        mem_we    <= (pick_id == ID_DC) ? dc_we : 1'b0;
                        mem_wline <= (pick_id == ID_DC) ? dc_wline : '0;
                        cnt       <= '0;
                        state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    cnt <= cnt + CNT_W'(1);
                    if (last_beat) begin
                        if (!mem_we) begin
                            if (grant_id == ID_DC) dc_line <= mem_rline;
                            else                   ic_line <= mem_rline;
                        end
                        ic_ack    <= (grant_id == ID_IC);
                        dc_ack    <= (grant_id == ID_DC);
                        mem_en    <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wline <= '0;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy       <= 1'b0;
                    last_grant <= grant_id;
                    state      <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Bench for mem_refill_arbiter: directed vector table, corner sequences, then random traffic
// checked every cycle against a timestamp-based transaction model.
module tb_mem_refill_arbiter;

    localparam int L = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ic_req = 1'b0, dc_req = 1'b0, dc_we = 1'b0;
    logic [15:0] ic_addr = '0, dc_addr = '0;
    logic [63:0] dc_wline = '0, mem_rline = '0;
    logic        ic_ack, dc_ack, mem_en, mem_we, busy, grant_id;
    logic [15:0] mem_addr;
    logic [63:0] ic_line, dc_line, mem_wline;

    int total = 0;
    int bad   = 0;

    mem_refill_arbiter dut (
        .clk(clk), .rst(rst),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_ack(ic_ack), .ic_line(ic_line),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wline(dc_wline),
        .dc_ack(dc_ack), .dc_line(dc_line),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wline(mem_wline),
        .mem_rline(mem_rline), .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Transaction model: a grant at edge T owns the port for edges T..T+L, ack shows after edge T+L.
    int          cyc = 0;
    int          m_t = 0;
    logic        m_busy = 1'b0, m_last = 1'b1, m_id = 1'b0, m_we = 1'b0;
    logic [15:0] m_addr = '0;
    logic [63:0] m_wl = '0, m_icl = '0, m_dcl = '0;
    logic        chk_en = 1'b0;

    function automatic logic win(input logic i, input logic d, input logic last);
        return (i && d) ? !last : d;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_busy <= 1'b0; m_last <= 1'b1; m_icl <= '0; m_dcl <= '0;
        end else if (!m_busy) begin
            if (ic_req || dc_req) begin
                m_busy <= 1'b1;
                m_t    <= cyc + 1;
                m_id   <= win(ic_req, dc_req, m_last);
                m_addr <= (win(ic_req, dc_req, m_last) ? dc_addr : ic_addr) & 16'hFFF8;
                m_we   <= win(ic_req, dc_req, m_last) && dc_we;
                m_wl   <= win(ic_req, dc_req, m_last) ? dc_wline : 64'd0;
            end
        end else begin
            if (cyc + 1 == m_t + L && !m_we) begin
                if (m_id) m_dcl <= mem_rline;
                else      m_icl <= mem_rline;
            end
            if (cyc + 1 == m_t + L + 1) begin
                m_busy <= 1'b0;
                m_last <= m_id;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int   ph;
            logic act;
            ph  = cyc - m_t;
            act = m_busy && ph < L;
            chk("m_mem_en", mem_en, act);
            chk("m_mem_addr", mem_addr, act ? m_addr : 16'd0);
            chk("m_mem_we", mem_we, act && m_we);
            chk("m_mem_wline", mem_wline, act ? m_wl : 64'd0);
            chk("m_ic_ack", ic_ack, m_busy && ph == L && !m_id);
            chk("m_dc_ack", dc_ack, m_busy && ph == L && m_id);
            chk("m_busy", busy, m_busy && ph <= L);
            if (m_busy && ph <= L) chk("m_grant_id", grant_id, m_id);
            chk("m_ic_line", ic_line, m_icl);
            chk("m_dc_line", dc_line, m_dcl);
        end
    end

    typedef struct {
        logic        ic, dc, we;
        logic [15:0] ic_addr, dc_addr;
        logic [63:0] wline, rline;
        logic        e_id;
        logic [15:0] e_addr;
        logic        e_we;
        logic [63:0] e_wline, e_line;
    } vec_t;

    vec_t tbl[6];

    task automatic run_vec(input vec_t v);
        ic_req = v.ic; ic_addr = v.ic_addr;
        dc_req = v.dc; dc_we = v.we; dc_addr = v.dc_addr; dc_wline = v.wline;
        mem_rline = v.rline;
        for (int i = 0; i < L; i++) begin
            @(negedge clk);
            chk("v_mem_en", mem_en, 1'b1);
            chk("v_mem_addr", mem_addr, v.e_addr);
            chk("v_mem_we", mem_we, v.e_we);
            chk("v_mem_wline", mem_wline, v.e_wline);
        end
        @(negedge clk);
        chk("v_acks", {ic_ack, dc_ack}, v.e_id ? 2'b01 : 2'b10);
        chk("v_mem_en_off", mem_en, 1'b0);
        chk("v_line", v.e_id ? dc_line : ic_line, v.e_line);
        ic_req = 1'b0; dc_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; ic_req = 1'b0; dc_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic both_pair(output int tic, output int tdc);
        ic_req = 1'b1; dc_req = 1'b1; dc_we = 1'b0;
        ic_addr = 16'($urandom); dc_addr = 16'($urandom);
        tic = -1; tdc = -1;
        for (int c = 0; c < 40 && (tic < 0 || tdc < 0); c++) begin
            @(negedge clk);
            mem_rline = {$urandom, $urandom};
            if (ic_ack) begin tic = c; ic_req = 1'b0; end
            if (dc_ack) begin tdc = c; dc_req = 1'b0; end
        end
        ic_req = 1'b0; dc_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        ic_req = 1'b0; dc_req = 1'b0;
        n = 0;
        while (busy && n < 20) begin @(negedge clk); n++; end
        chk("drain_timeout", n < 20, 1'b1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int   tic, tdc, n, gap, ngr;
        logic seen, prev_en, ic_wait, dc_wait;
        logic grants[6];

        tbl[0] = '{1, 0, 0, 16'h1234, 16'h0000, 64'h0, 64'h1111_2222_3333_4444,
                   0, 16'h1230, 0, 64'h0, 64'h1111_2222_3333_4444};
        tbl[1] = '{0, 1, 1, 16'h0000, 16'h004F, 64'hA5A5_0000_FFFF_1234, 64'h0BAD_0BAD_0BAD_0BAD,
                   1, 16'h0048, 1, 64'hA5A5_0000_FFFF_1234, 64'h0};
        tbl[2] = '{0, 1, 0, 16'h0000, 16'hFFFF, 64'h5555_6666_7777_8888, 64'hDEAD_BEEF_0123_4567,
                   1, 16'hFFF8, 0, 64'h5555_6666_7777_8888, 64'hDEAD_BEEF_0123_4567};
        tbl[3] = '{0, 1, 1, 16'h0000, 16'h8008, 64'h0123_4567_89AB_CDEF, 64'h7777_7777_7777_7777,
                   1, 16'h8008, 1, 64'h0123_4567_89AB_CDEF, 64'hDEAD_BEEF_0123_4567};
        tbl[4] = '{1, 0, 0, 16'h0007, 16'h0000, 64'h0, 64'hCAFE_F00D_1357_9BDF,
                   0, 16'h0000, 0, 64'h0, 64'hCAFE_F00D_1357_9BDF};
        tbl[5] = '{1, 0, 0, 16'hFFF9, 16'h0000, 64'h0, 64'h0,
                   0, 16'hFFF8, 0, 64'h0, 64'h0};

        @(posedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_acks", {ic_ack, dc_ack}, 2'b00);
        chk("rst_lines", ic_line | dc_line, 64'h0);
        chk("rst_mem_bus", {mem_we, mem_addr, mem_wline, grant_id}, '0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_mem_en", mem_en, 1'b0);
        chk("idle_busy", busy, 1'b0);

        foreach (tbl[i]) run_vec(tbl[i]);

        // Simultaneous requests straight out of reset: IC wins the first tie.
        do_reset();
        both_pair(tic, tdc);
        chk("both1_ic_first", tic >= 0 && tic < tdc, 1'b1);
        chk("both1_dc_gap", 64'(tdc - tic), 64'(L + 2));
        both_pair(tic, tdc);
        chk("both2_ic_first", tic >= 0 && tic < tdc, 1'b1);

        // Reset during the third access cycle aborts without an ack.
        ic_req = 1'b1; ic_addr = 16'h2222; mem_rline = 64'h9999_9999_9999_9999;
        n = 0;
        for (int c = 0; c < 10 && n < 3; c++) begin
            @(negedge clk);
            if (mem_en) n++;
        end
        chk("rst_mid_reached", 64'(n), 64'd3);
        rst = 1'b1; ic_req = 1'b0;
        @(negedge clk);
        chk("rst_mid_mem_en", mem_en, 1'b0);
        chk("rst_mid_ic_line", ic_line, 64'h0);
        rst = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (ic_ack) seen = 1'b1;
        end
        chk("rst_mid_no_ack", seen, 1'b0);
        run_vec(tbl[0]);

        // DC always requesting, IC re-requests right after each ack: grants alternate.
        ic_req = 1'b1; dc_req = 1'b1; dc_we = 1'b0;
        prev_en = 1'b0; gap = 0; ngr = 0;
        for (int c = 0; c < 80 && ngr < 6; c++) begin
            @(negedge clk);
            mem_rline = {$urandom, $urandom};
            if (mem_en && !prev_en) begin
                grants[ngr] = grant_id;
                if (ngr > 0) chk("alt_gap", 64'(gap), 64'd2);
                ngr++;
            end
            gap = mem_en ? 0 : gap + 1;
            prev_en = mem_en;
            if (ic_ack)       ic_req = 1'b0;
            else if (!ic_req) ic_req = 1'b1;
        end
        chk("alt_count", 64'(ngr), 64'd6);
        for (int i = 1; i < 6; i++) chk("alt_order", grants[i] != grants[i-1], 1'b1);
        drain();

        // Random traffic: per-cycle model checks do the comparing.
        ic_wait = 1'b0; dc_wait = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            mem_rline = {$urandom, $urandom};
            if (ic_ack) begin
                ic_req = 1'b0; ic_wait = 1'b0;
            end else if (!ic_wait) begin
                if ($urandom_range(0, 3) == 0) begin
                    ic_wait = 1'b1; ic_req = 1'b1; ic_addr = 16'($urandom);
                end
            end else begin
                if ($urandom_range(0, 7) == 0) ic_addr = 16'($urandom);
                if (busy && grant_id == 1'b0 && mem_en && $urandom_range(0, 15) == 0) ic_req = 1'b0;
            end
            if (dc_ack) begin
                dc_req = 1'b0; dc_wait = 1'b0;
            end else if (!dc_wait) begin
                if ($urandom_range(0, 3) == 0) begin
                    dc_wait = 1'b1; dc_req = 1'b1; dc_addr = 16'($urandom);
                    dc_we = 1'($urandom); dc_wline = {$urandom, $urandom};
                end
            end else begin
                if ($urandom_range(0, 7) == 0) begin
                    dc_addr = 16'($urandom); dc_wline = {$urandom, $urandom};
                end
                if (busy && grant_id == 1'b1 && mem_en && $urandom_range(0, 15) == 0) dc_req = 1'b0;
            end
        end
        drain();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
